benes16_stream_ctrl: RTL and testbench

- Streaming front/back end for the 16-lane combinational Benes permutation network.
- Collects 16 serial N-bit words plus one 7-bit switch-control word and presents them in parallel on the network inputs.
- Captures the 16 permuted network outputs into a second buffer and streams them back out serially, with valid/ready on both sides.
- Input and output buffers are independent, so frame k+1 loads while frame k drains.

---
 rtl/benes16_stream_ctrl.sv | 106 ++++++++++
 tb/tb_benes16_stream_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/benes16_stream_ctrl.sv
// Serial-to-parallel loader and parallel-to-serial drainer around a 16-lane Benes network; capture 1 cycle after the last input beat.
// Input stalls (in_ready low) while a full frame waits for the output buffer; output holds data/idx while out_ready is low.
module benes16_stream_ctrl #(
    parameter int N   = 32,
    parameter int B16 = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_data,
    input  logic [B16-1:0]  in_cfg,
    output logic [16*N-1:0] net_x,
    output logic [B16-1:0]  net_s,
    input  logic [16*N-1:0] net_y,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_data,
    output logic [3:0]      out_idx,
    output logic            out_last
);

    typedef enum logic {LOAD,  FULL}  in_st_t;
    typedef enum logic {EMPTY, DRAIN} out_st_t;

    in_st_t     in_st, in_nxt;
    out_st_t    out_st, out_nxt;
    logic [3:0] wr_cnt;
    logic [N-1:0] out_buf [16];

    logic in_acc;
    logic out_acc;
    logic out_free;
    logic capture;

    assign in_acc   = in_valid && in_ready;
    assign out_acc  = out_valid && out_ready;
    // The buffer counts as free on the edge its last beat leaves, so frames run back to back.
    assign out_free = !out_valid || (out_acc && (out_idx == 4'd15));
    assign capture  = (in_st == FULL) && out_free;

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_st  <= LOAD;
            out_st <= EMPTY;
        end else begin
            in_st  <= in_nxt;
            out_st <= out_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        in_nxt = in_st;
        case (in_st)
            LOAD: if (in_acc && (wr_cnt == 4'd15)) in_nxt = FULL;
            FULL: if (capture) in_nxt = LOAD;
            default: in_nxt = LOAD;
        endcase
    end

    always_comb begin
        out_nxt = out_st;
        case (out_st)
            EMPTY: if (capture) out_nxt = DRAIN;
            DRAIN: if (!capture && out_acc && (out_idx == 4'd15)) out_nxt = EMPTY;
            default: out_nxt = EMPTY;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = (in_st == LOAD);
        out_valid = (out_st == DRAIN);
        out_last  = (out_st == DRAIN) && (out_idx == 4'd15);
        out_data  = out_buf[out_idx];
    end

    // Input buffer: lanes drive the network directly and hold while FULL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt <= '0;
            net_x  <= '0;
            net_s  <= '0;
        end else if (in_acc) begin
            net_x[int'(wr_cnt)*N +: N] <= in_data;
            if (wr_cnt == 4'd0) net_s <= in_cfg;
            wr_cnt <= wr_cnt + 4'd1;
        end
    end

    // Output buffer and read pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) out_buf[k] <= '0;
            out_idx <= '0;
        end else if (capture) begin
            for (int k = 0; k < 16; k++) out_buf[k] <= net_y[k*N +: N];
            out_idx <= '0;
        end else if (out_acc) begin
            out_idx <= out_idx + 4'd1;
        end
    end

endmodule

// File: tb/tb_benes16_stream_ctrl.sv
// Bench for benes16_stream_ctrl with a lane-reversing stub network and a frame-level reference queue.
module tb_benes16_stream_ctrl;
    localparam int N = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_data;
    logic [6:0]     in_cfg;
    logic [16*N-1:0] net_x;
    logic [6:0]     net_s;
    logic [16*N-1:0] net_y;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [N-1:0]   out_data;
    logic [3:0]     out_idx;
    logic           out_last;

    benes16_stream_ctrl #(.N(N), .B16(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_cfg(in_cfg),
        .net_x(net_x), .net_s(net_s), .net_y(net_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Stub network: output lane k carries input lane 15-k.
    always_comb begin
        net_y = '0;
        for (int k = 0; k < 16; k++) net_y[k*N +: N] = net_x[(15-k)*N +: N];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: each completed frame queues 16 {idx, word} beats, word j = input beat 15-j.
    logic [35:0] exp_q[$];
    logic [31:0] frame [16];
    int          nbeat = 0;
    logic [6:0]  cfg0;

    // out_ready driver: 0 hold, 1 pattern 1,0,0,1, 2 random, 3 stop at idx 5
    int         rmode = 0;
    logic       rdy_hold = 1'b1;
    int         pi = 0;
    logic [3:0] pat = 4'b1001;

    always @(posedge clk) begin
        #1;
        case (rmode)
            0: out_ready = rdy_hold;
            1: begin out_ready = pat[pi]; pi = (pi + 1) % 4; end
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = (out_idx != 4'd5);
        endcase
    end

    // Output monitor
    logic        stalled = 1'b0;
    logic [31:0] hold_d;
    logic [3:0]  hold_i;
    logic        last_seen = 1'b0;
    logic        last_full = 1'b0;
    logic [35:0] mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled   = 1'b0;
            last_seen = 1'b0;
        end else begin
            if (last_seen) begin
                chk("valid_after_last", {31'd0, out_valid}, {31'd0, last_full});
                if (last_full) chk("idx_after_boundary", {28'd0, out_idx}, 32'd0);
                last_seen = 1'b0;
            end
            if (stalled) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_data", out_data, hold_d);
                chk("hold_idx", {28'd0, out_idx}, {28'd0, hold_i});
                stalled = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_beat", {31'd0, out_valid}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_data", out_data, mon_e[31:0]);
                    chk("out_idx", {28'd0, out_idx}, {28'd0, mon_e[35:32]});
                    chk("out_last", {31'd0, out_last}, {31'd0, mon_e[35:32] == 4'd15});
                    if (out_last) begin
                        last_seen = 1'b1;
                        last_full = !in_ready;
                    end
                end
            end else if (out_valid) begin
                stalled = 1'b1;
                hold_d  = out_data;
                hold_i  = out_idx;
            end
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic [6:0] c, input int idle);
        int t;
        repeat (idle) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = d;
        in_cfg   = c;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 200) begin
                chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        frame[nbeat] = d;
        if (nbeat == 0) cfg0 = c;
        chk("net_s", {25'd0, net_s}, {25'd0, cfg0});
        chk("net_x_lane", net_x[nbeat*N +: N], d);
        nbeat++;
        if (nbeat == 16) begin
            nbeat = 0;
            chk("in_ready_full", {31'd0, in_ready}, 32'd0);
            for (int k = 0; k < 16; k++) chk("net_x_frame", net_x[k*N +: N], frame[k]);
            for (int j = 0; j < 16; j++) exp_q.push_back({4'(j), frame[15-j]});
            if (!out_valid) begin
                @(posedge clk); #1;
                chk("capture_valid", {31'd0, out_valid}, 32'd1);
                chk("capture_in_ready", {31'd0, in_ready}, 32'd1);
                chk("capture_idx", {28'd0, out_idx}, 32'd0);
            end
        end
    endtask

    task automatic send_frame(input logic [6:0] c0, input logic [6:0] crest, input bit rnd, input bit stalls);
        for (int i = 0; i < 16; i++)
            send_beat(rnd ? $urandom : 32'(i), (i == 0) ? c0 : crest,
                      stalls ? int'($urandom_range(0, 3)) : 0);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_cfg   = '0;
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_idx", {28'd0, out_idx}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_net_s", {25'd0, net_s}, 32'd0);
        for (int k = 0; k < 16; k++) chk("rst_net_x", net_x[k*N +: N], 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single frame, counting data, free-running output
        rmode = 0; rdy_hold = 1'b1;
        send_frame(7'h55, 7'h55, 1'b0, 1'b0);
        wait_drain();

        // Output backpressure 1,0,0,1
        rmode = 1;
        send_frame(7'($urandom), 7'($urandom), 1'b1, 1'b0);
        wait_drain();

        // Two frames back to back while the output is blocked
        rmode = 0; rdy_hold = 1'b0;
        @(posedge clk); #1;
        send_frame(7'h12, 7'h34, 1'b1, 1'b0);
        send_frame(7'h21, 7'h43, 1'b1, 1'b0);
        chk("overlap_full", {31'd0, in_ready}, 32'd0);
        chk("overlap_valid", {31'd0, out_valid}, 32'd1);
        rdy_hold = 1'b1;
        wait_drain();

        // cfg only sampled with beat 0
        send_frame(7'h00, 7'h7F, 1'b1, 1'b0);
        wait_drain();

        // Random input stalls and random out_ready
        rmode = 2;
        for (int f = 0; f < 3; f++) send_frame(7'($urandom), 7'($urandom), 1'b1, 1'b1);
        wait_drain();

        // Reset with 7 input beats loaded and output parked at idx 5
        rmode = 0; rdy_hold = 1'b0;
        @(posedge clk); #1;
        send_frame(7'h0A, 7'h0B, 1'b1, 1'b0);
        rmode = 3;
        t = 0;
        while (out_idx != 4'd5 && t < 200) begin @(posedge clk); #1; t++; end
        for (int i = 0; i < 7; i++) send_beat($urandom, 7'h3C, 0);
        @(posedge clk); #1;
        chk("pre_reset_idx", {28'd0, out_idx}, 32'd5);
        chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_out_idx", {28'd0, out_idx}, 32'd0);
        chk("mid_rst_net_s", {25'd0, net_s}, 32'd0);
        for (int k = 0; k < 16; k++) chk("mid_rst_net_x", net_x[k*N +: N], 32'd0);
        exp_q.delete();
        nbeat = 0;
        rmode = 0; rdy_hold = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("post_rst_no_beat", {31'd0, out_valid}, 32'd0);
        end
        send_frame(7'h66, 7'h11, 1'b1, 1'b0);
        wait_drain();

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
